// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - two-requester round-robin arbiter around one shared 16-bit adder
// One operation in flight: IDLE grants, EXEC registers sum and flags, RESP holds until consumed.
module add_arbiter #(
  parameter int START_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_z,
  output logic        rsp_carry,
  output logic        rsp_sign,
  output logic        rsp_parity,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Pointer holds the last granted requester, so reset seeds it with the other one.
  localparam logic RESET_LAST = (START_PRIO == 0) ? 1'b1 : 1'b0;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q;
  logic [15:0] x_q, y_q;
  logic [15:0] z_q;
  logic        carry_q, sign_q, parity_q, zero_q, ovf_q;
  logic        rsp_id_q;

  logic        grant_id;
  logic        hs;
  logic [16:0] sum;

  always_comb begin
    grant_id = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_q;
    end
  end

  assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !grant_id;
  assign req1_ready = !rst && (state_q == IDLE) && req1_valid && grant_id;
  assign hs         = req0_ready | req1_ready;

  assign sum = {1'b0, x_q} + {1'b0, y_q};

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          last_d  = rsp_id_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= RESET_LAST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= 16'h0000;
      y_q      <= 16'h0000;
      id_q     <= 1'b0;
      z_q      <= 16'h0000;
      carry_q  <= 1'b0;
      sign_q   <= 1'b0;
      parity_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rsp_id_q <= 1'b0;
    end else begin
      if (hs) begin
        x_q  <= grant_id ? req1_x : req0_x;
        y_q  <= grant_id ? req1_y : req0_y;
        id_q <= grant_id;
      end
      if (state_q == EXEC) begin
        z_q      <= sum[15:0];
        carry_q  <= sum[16];
        sign_q   <= sum[15];
        parity_q <= ^sum[15:0];
        zero_q   <= (sum[15:0] == 16'h0000);
        ovf_q    <= (x_q[15] == y_q[15]) && (sum[15] != x_q[15]);
        rsp_id_q <= id_q;
      end
    end
  end

  assign rsp_valid    = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  assign rsp_id       = rsp_id_q;
  assign rsp_z        = z_q;
  assign rsp_carry    = carry_q;
  assign rsp_sign     = sign_q;
  assign rsp_parity   = parity_q;
  assign rsp_zero     = zero_q;
  assign rsp_overflow = ovf_q;

endmodule
